dm_cache_ctrl: RTL and testbench

Direct-mapped cache controller. It is the initiator side of the tag-RAM and data-RAM interfaces: it drives index, write-enable and write data, consumes the asynchronous read data, and compares tags. It sits between the CPU load/store port and the lower memory. Policy: write-through, no-write-allocate, read-allocate.

---
 rtl/dm_cache_pkg.sv | 36 +++
 rtl/dm_cache_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_pkg.sv
// Shared types and helpers for the direct-mapped cache controller.
// Holds default geometry, the FSM state enum and address field helpers.
package dm_cache_pkg;

  localparam int DM_ADDR_W   = 32;
  localparam int DM_DATA_W   = 32;
  localparam int DM_INDEX_W  = 10;
  localparam int DM_OFFSET_W = 2;
  localparam int DM_TAG_W    = DM_ADDR_W - DM_INDEX_W - DM_OFFSET_W;

  // Tag-RAM entry layout is {valid, tag}.
  localparam int VALID_BIT = DM_TAG_W;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    RESP
  } state_t;

  function automatic logic [DM_INDEX_W-1:0] idx_of(
    input logic [DM_ADDR_W-1:0] addr
  );
    return addr[DM_OFFSET_W +: DM_INDEX_W];
  endfunction

  function automatic logic [DM_TAG_W-1:0] tag_of(
    input logic [DM_ADDR_W-1:0] addr
  );
    return addr[DM_ADDR_W-1 -: DM_TAG_W];
  endfunction

endpackage

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate, read-allocate cache
// controller. Ports: clk/rst_n; CPU req/resp; tag-RAM and data-RAM
// initiator side (async read, registered index/we/wdata); lower-memory
// req/resp handshake.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W   = DM_ADDR_W,
  parameter int DATA_W   = DM_DATA_W,
  parameter int INDEX_W  = DM_INDEX_W,
  parameter int OFFSET_W = DM_OFFSET_W,
  parameter int TAG_W    = DM_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              tag_w_en,
  output logic [INDEX_W-1:0] tag_addr,
  output logic [TAG_W:0]    tag_wdata,
  input  logic [TAG_W:0]    tag_rdata,
  output logic              data_w_en,
  output logic [INDEX_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  // Offset bits are cleared at capture so the stored address is
  // already the word-aligned memory address.
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((1 << OFFSET_W) - 1);

  state_t state, state_nx;

  logic [INDEX_W-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0]  addr_q, addr_nx;
  logic               we_q, we_nx;
  logic [DATA_W-1:0]  wdata_q, wdata_nx;
  logic [DATA_W-1:0]  rdata_q, rdata_nx;
  logic               hit_q, hit_nx;
  logic               hit;
  logic               init_wr;

  logic               tag_w_en_nx;
  logic [INDEX_W-1:0] tag_addr_nx;
  logic [TAG_W:0]     tag_wdata_nx;
  logic               data_w_en_nx;
  logic [INDEX_W-1:0] data_addr_nx;
  logic [DATA_W-1:0]  data_wdata_nx;

  assign hit = tag_rdata[VALID_BIT] &&
    (tag_rdata[TAG_W-1:0] == tag_of(addr_q));

  assign cpu_req_ready  = (state == IDLE);
  assign cpu_resp_valid = (state == RESP);
  assign cpu_resp_rdata = rdata_q;

  assign mem_req_valid = (state == MEM_REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    addr_nx       = addr_q;
    we_nx         = we_q;
    wdata_nx      = wdata_q;
    rdata_nx      = rdata_q;
    hit_nx        = hit_q;
    init_wr       = 1'b0;
    tag_w_en_nx   = 1'b0;
    tag_wdata_nx  = '0;
    data_w_en_nx  = 1'b0;
    data_wdata_nx = '0;

    unique case (state)
      INIT: begin
        // Leave once the last index write has been presented.
        if (tag_w_en && tag_addr == '1) begin
          state_nx = IDLE;
        end else begin
          init_wr     = 1'b1;
          tag_w_en_nx = 1'b1;
          cnt_nx      = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (cpu_req_valid) begin
          addr_nx  = cpu_req_addr & ~OFF_MASK;
          we_nx    = cpu_req_we;
          wdata_nx = cpu_req_wdata;
          rdata_nx = '0;
          state_nx = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!we_q && hit) begin
          rdata_nx = data_rdata;
          state_nx = RESP;
        end else begin
          hit_nx   = hit;
          state_nx = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_req_ready) state_nx = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_resp_valid) begin
          if (!we_q) begin
            rdata_nx      = mem_resp_rdata;
            data_w_en_nx  = 1'b1;
            data_wdata_nx = mem_resp_rdata;
            tag_w_en_nx   = 1'b1;
            tag_wdata_nx  = {1'b1, tag_of(addr_q)};
            state_nx      = FILL;
          end else if (hit_q) begin
            data_w_en_nx  = 1'b1;
            data_wdata_nx = wdata_q;
            state_nx      = FILL;
          end else begin
            state_nx = RESP;
          end
        end
      end
      FILL:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = INIT;
    endcase

    data_addr_nx = idx_of(addr_nx);
    tag_addr_nx  = init_wr ? cnt : idx_of(addr_nx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= INIT;
      cnt        <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      tag_w_en   <= 1'b0;
      tag_addr   <= '0;
      tag_wdata  <= '0;
      data_w_en  <= 1'b0;
      data_addr  <= '0;
      data_wdata <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      addr_q     <= addr_nx;
      we_q       <= we_nx;
      wdata_q    <= wdata_nx;
      rdata_q    <= rdata_nx;
      hit_q      <= hit_nx;
      tag_w_en   <= tag_w_en_nx;
      tag_addr   <= tag_addr_nx;
      tag_wdata  <= tag_wdata_nx;
      data_w_en  <= data_w_en_nx;
      data_addr  <= data_addr_nx;
      data_wdata <= data_wdata_nx;
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with tag/data RAM models, a scripted
// lower memory and a response scoreboard.
module tb_dm_cache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        tag_w_en;
  logic [9:0]  tag_addr;
  logic [20:0] tag_wdata;
  logic [20:0] tag_rdata;
  logic        data_w_en;
  logic [9:0]  data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  dm_cache_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .tag_w_en       (tag_w_en),
    .tag_addr       (tag_addr),
    .tag_wdata      (tag_wdata),
    .tag_rdata      (tag_rdata),
    .data_w_en      (data_w_en),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_rdata     (data_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [20:0] tag_ram  [1024];
  logic [31:0] data_ram [1024];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] exp_q [$];

  int n_tag_wr = 0;
  int n_data_wr = 0;
  int n_resp = 0;
  int n_mem = 0;
  int unstable = 0;
  int rdly = 0;
  int sdly = 0;
  logic [9:0]  last_tag_addr;
  logic [20:0] last_tag_wdata;
  logic [9:0]  last_data_addr;
  logic [31:0] last_data_wdata;
  logic [31:0] last_maddr;
  logic [31:0] last_mwdata;
  logic        last_mwe;

  assign tag_rdata  = tag_ram[tag_addr];
  assign data_rdata = data_ram[data_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM models: writes land on the falling edge.
  always @(negedge clk) begin
    if (tag_w_en === 1'b1) begin
      tag_ram[tag_addr] <= tag_wdata;
      n_tag_wr++;
      last_tag_addr  = tag_addr;
      last_tag_wdata = tag_wdata;
    end
    if (data_w_en === 1'b1) begin
      data_ram[data_addr] <= data_wdata;
      n_data_wr++;
      last_data_addr  = data_addr;
      last_data_wdata = data_wdata;
    end
    if (cpu_resp_valid === 1'b1) n_resp++;
  end

  // Response scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (cpu_resp_valid === 1'b1) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 'x;
      chk("resp_rdata", 64'(cpu_resp_rdata), 64'(e));
    end
  end

  // Lower memory with programmable ready and response delays.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid === 1'b1) begin
        n_mem++;
        last_maddr  = mem_req_addr;
        last_mwe    = mem_req_we;
        last_mwdata = mem_req_wdata;
        for (int k = 0; k < rdly; k++) begin
          @(negedge clk);
          if (mem_req_valid !== 1'b1 || mem_req_addr !== last_maddr ||
              mem_req_wdata !== last_mwdata || mem_req_we !== last_mwe)
            unstable++;
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        if (last_mwe) mem_model[last_maddr] = last_mwdata;
        repeat (sdly) @(negedge clk);
        mem_resp_valid = 1'b1;
        if (last_mwe) mem_resp_rdata = 32'h0;
        else if (mem_model.exists(last_maddr))
          mem_resp_rdata = mem_model[last_maddr];
        else mem_resp_rdata = 32'h0;
        @(negedge clk);
        mem_resp_valid = 1'b0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [31:0] exp,
                        output int lat, output int rdy_hi);
    int to;
    exp_q.push_back(exp);
    to = 0;
    while (cpu_req_ready !== 1'b1 && to < 2000) begin
      @(negedge clk);
      to++;
    end
    chk("req_ready_wait", 64'(to < 2000), 64'(1));
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat    = 1;
    rdy_hi = 0;
    while (cpu_resp_valid !== 1'b1 && lat < 300) begin
      if (cpu_req_ready === 1'b1) rdy_hi++;
      @(negedge clk);
      lat++;
    end
    chk("resp_seen", 64'(cpu_resp_valid), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    int bad, lat, rh, m0, t0, d0, r0;
    for (int i = 0; i < 1024; i++) begin
      tag_ram[i]  = {1'b1, 20'h00001};
      data_ram[i] = 32'hBAD0_0000 | i;
    end
    mem_model[32'h0000_1234] = 32'hDEADBEEF;
    mem_model[32'h0000_2234] = 32'h2222_3333;
    mem_model[32'h0000_3000] = 32'h55AA_55AA;
    rst_n = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;

    // 1: reset state and INIT sweep
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 64'({tag_w_en, data_w_en, cpu_req_ready,
        cpu_resp_valid, mem_req_valid, mem_req_we}), 64'(0));
    chk("rst_addr", 64'({tag_addr, data_addr, tag_wdata}), 64'(0));
    chk("rst_mem", 64'({mem_req_addr, mem_req_wdata}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!(tag_w_en === 1'b1 && tag_addr === 10'(i) &&
            tag_wdata === 21'h0 && cpu_req_ready === 1'b0)) bad++;
      @(negedge clk);
    end
    chk("init_sweep_bad", 64'(bad), 64'(0));
    chk("ready_after_init", 64'(cpu_req_ready), 64'(1));
    chk("tag_we_after_init", 64'(tag_w_en), 64'(0));

    // 2: read miss with fill, then read hit
    m0 = n_mem; t0 = n_tag_wr; d0 = n_data_wr;
    do_req(1'b0, 32'h0000_1234, 32'h0, 32'hDEADBEEF, lat, rh);
    chk("miss_lat", 64'(lat), 64'(5));
    chk("miss_mem_n", 64'(n_mem - m0), 64'(1));
    chk("miss_mem_req", 64'({last_mwe, last_maddr}), 64'(32'h0000_1234));
    chk("fill_tag_n", 64'(n_tag_wr - t0), 64'(1));
    chk("fill_tag", 64'({last_tag_addr, last_tag_wdata}),
        64'({10'h08D, 21'h100001}));
    chk("fill_data_n", 64'(n_data_wr - d0), 64'(1));
    chk("fill_data", 64'({last_data_addr, last_data_wdata}),
        64'({10'h08D, 32'hDEADBEEF}));
    m0 = n_mem;
    do_req(1'b0, 32'h0000_1234, 32'h0, 32'hDEADBEEF, lat, rh);
    chk("hit_lat", 64'(lat), 64'(2));
    chk("hit_mem_n", 64'(n_mem - m0), 64'(0));

    // 3: conflict miss on same index
    m0 = n_mem;
    do_req(1'b0, 32'h0000_2234, 32'h0, 32'h2222_3333, lat, rh);
    chk("conf_mem_n", 64'(n_mem - m0), 64'(1));
    chk("conf_tag", 64'({last_tag_addr, last_tag_wdata}),
        64'({10'h08D, 21'h100002}));
    m0 = n_mem;
    do_req(1'b0, 32'h0000_1234, 32'h0, 32'hDEADBEEF, lat, rh);
    chk("reload_mem_n", 64'(n_mem - m0), 64'(1));

    // 4: store hit then load hit; store miss
    m0 = n_mem; t0 = n_tag_wr; d0 = n_data_wr;
    do_req(1'b1, 32'h0000_1234, 32'hCAFEF00D, 32'h0, lat, rh);
    chk("sthit_mem", 64'({last_mwe, last_maddr, last_mwdata}),
        64'({1'b1, 32'h0000_1234, 32'hCAFEF00D}));
    chk("sthit_mem_n", 64'(n_mem - m0), 64'(1));
    chk("sthit_tag_n", 64'(n_tag_wr - t0), 64'(0));
    chk("sthit_data_n", 64'(n_data_wr - d0), 64'(1));
    chk("sthit_data", 64'({last_data_addr, last_data_wdata}),
        64'({10'h08D, 32'hCAFEF00D}));
    m0 = n_mem;
    do_req(1'b0, 32'h0000_1234, 32'h0, 32'hCAFEF00D, lat, rh);
    chk("ld_after_st_mem_n", 64'(n_mem - m0), 64'(0));
    m0 = n_mem; t0 = n_tag_wr; d0 = n_data_wr;
    do_req(1'b1, 32'h0000_5000, 32'h1234_5678, 32'h0, lat, rh);
    chk("stmiss_lat", 64'(lat), 64'(4));
    chk("stmiss_mem_n", 64'(n_mem - m0), 64'(1));
    chk("stmiss_ram_n", 64'((n_tag_wr - t0) + (n_data_wr - d0)), 64'(0));

    // 5: slow memory handshake
    rdly = 5; sdly = 7; unstable = 0; r0 = n_resp;
    do_req(1'b0, 32'h0000_3000, 32'h0, 32'h55AA_55AA, lat, rh);
    repeat (3) @(negedge clk);
    chk("slow_lat", 64'(lat), 64'(17));
    chk("slow_stable", 64'(unstable), 64'(0));
    chk("slow_ready_low", 64'(rh), 64'(0));
    chk("slow_one_resp", 64'(n_resp - r0), 64'(1));

    // 6: reset during MEM_WAIT, stale response afterwards
    rdly = 0; sdly = 10; r0 = n_resp;
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 32'h0000_4000;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_in_wait", 64'({cpu_req_ready, mem_req_valid}), 64'(0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_outs_zero", 64'({mem_req_valid, tag_w_en,
        data_w_en, cpu_req_ready, cpu_resp_valid}), 64'(0));
    @(negedge clk);
    chk("reinit_first", 64'({tag_w_en, tag_addr}), 64'({1'b1, 10'h0}));
    repeat (1030) @(negedge clk);
    chk("reinit_ready", 64'(cpu_req_ready), 64'(1));
    chk("abort_no_resp", 64'(n_resp - r0), 64'(0));
    sdly = 0;
    m0 = n_mem;
    do_req(1'b0, 32'h0000_1234, 32'h0, 32'hCAFEF00D, lat, rh);
    chk("post_reinit_miss", 64'(n_mem - m0), 64'(1));

    // index wrap: top address maps to index 1023, tag 0xFFFFF
    do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, lat, rh);
    chk("wrap_tag", 64'({last_tag_addr, last_tag_wdata}),
        64'({10'h3FF, 21'h1FFFFF}));
    chk("wrap_mem_addr", 64'(last_maddr), 64'(32'hFFFF_FFFC));

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
